// File: rtl/stream_sink_checker.sv
// Downstream valid/ready sink for stream testing. Drives u_ready with an
// LFSR-shaped stall pattern, checks each accepted beat against an
// incrementing expected value, and watches upstream for hold-rule breaks.
module stream_sink_checker #(
   parameter int          DATA_WIDTH   = 32,
   parameter int          COUNT_WIDTH  = 16,
   parameter int          EXPECT_COUNT = 100,
   parameter int          DATA_START   = 0,
   parameter int          STALL_N      = 2,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [DATA_WIDTH-1:0]  u_data,
   input  logic                   u_valid,
   output logic                   u_ready,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [COUNT_WIDTH-1:0] rx_count,
   output logic [COUNT_WIDTH-1:0] err_count,
   output logic                   proto_err,
   output logic [DATA_WIDTH-1:0]  first_err_got,
   output logic [DATA_WIDTH-1:0]  first_err_exp
);

   typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_STALL, S_DONE} state_t;

   // A zero seed would lock the LFSR at zero forever.
   localparam logic [15:0]            LFSR_INIT  = (LFSR_SEED == 16'd0) ? 16'd1 : LFSR_SEED;
   localparam logic [7:0]             STALL_MOD  = 8'(STALL_N + 4);
   localparam logic [7:0]             STALL_OFF  = 8'(STALL_N);
   localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(EXPECT_COUNT - 1);
   localparam logic [DATA_WIDTH-1:0]  START_VAL  = DATA_WIDTH'(DATA_START);

   state_t                  r_state;
   state_t                  w_next;
   logic                    r_ready;
   logic [15:0]             r_lfsr;
   logic [1:0]              r_stall_cnt;
   logic [DATA_WIDTH-1:0]   r_expected;
   logic [COUNT_WIDTH-1:0]  r_rx_count;
   logic [COUNT_WIDTH-1:0]  r_err_count;
   logic [DATA_WIDTH-1:0]   r_first_got;
   logic [DATA_WIDTH-1:0]   r_first_exp;
   logic                    r_proto_err;
   logic                    r_prev_vld;
   logic                    r_prev_hs;
   logic [DATA_WIDTH-1:0]   r_prev_data;
   logic                    r_arm;

   logic                    w_start_ok;
   logic                    w_hs;
   logic                    w_mismatch;
   logic                    w_last;
   logic [7:0]              w_draw_r;
   logic [1:0]              w_stall;
   logic [15:0]             w_lfsr_next;
   logic                    w_hold_viol;

   // start is only honoured when no run is in flight.
   assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   // r_ready is only ever high in ACCEPT, so this is the handshake.
   assign w_hs        = u_valid && r_ready;
   // 4-state compare so X/Z data at a handshake counts as a mismatch.
   assign w_mismatch  = (u_data !== r_expected);
   assign w_last      = (r_rx_count == LAST_COUNT);
   // Stall draw uses the LFSR value before this handshake advances it.
   assign w_draw_r    = r_lfsr[7:0] % STALL_MOD;
   assign w_stall     = (w_draw_r > STALL_OFF) ? 2'(w_draw_r - STALL_OFF) : 2'd0;
   // Galois form, taps x^16+x^14+x^13+x^11+1 (maximal length).
   assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
   // A pending unaccepted beat must stay valid with identical data.
   assign w_hold_viol = r_arm && (r_state != S_IDLE) && r_prev_vld && !r_prev_hs &&
                        (!u_valid || (u_data !== r_prev_data));

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state decode.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (start) w_next = S_ACCEPT;
         S_ACCEPT: begin
            if (w_hs) begin
               if (w_last)              w_next = S_DONE;
               else if (w_stall != 2'd0) w_next = S_STALL;
            end
         end
         S_STALL:  if (r_stall_cnt <= 2'd1) w_next = S_ACCEPT;
         S_DONE:   if (start) w_next = S_ACCEPT;
         default:  w_next = S_IDLE;
      endcase
   end

   // Ready is registered from the next state so it has no input-to-output path.
   always_ff @(posedge clk) begin
      if (!rst_n) r_ready <= 1'b0;
      else        r_ready <= (w_next == S_ACCEPT);
   end

   // Stall counter: loaded by a stalling handshake, counts down in STALL.
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_stall_cnt <= 2'd0;
      else if ((r_state == S_ACCEPT) && w_hs && !w_last && (w_stall != 2'd0))
         r_stall_cnt <= w_stall;
      else if (r_state == S_STALL)
         r_stall_cnt <= r_stall_cnt - 2'd1;
   end

   // LFSR steps once per accepted beat and is not reloaded by start.
   always_ff @(posedge clk) begin
      if (!rst_n)    r_lfsr <= LFSR_INIT;
      else if (w_hs) r_lfsr <= w_lfsr_next;
   end

   // Beat checking: expected sequence, counters and first-error capture.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_expected  <= START_VAL;
         r_rx_count  <= '0;
         r_err_count <= '0;
         r_first_got <= '0;
         r_first_exp <= '0;
      end else if (w_start_ok) begin
         r_expected  <= START_VAL;
         r_rx_count  <= '0;
         r_err_count <= '0;
         r_first_got <= '0;
         r_first_exp <= '0;
      end else if (w_hs) begin
         r_expected <= r_expected + DATA_WIDTH'(1);
         r_rx_count <= r_rx_count + COUNT_WIDTH'(1);
         if (w_mismatch) begin
            if (r_err_count != '1) r_err_count <= r_err_count + COUNT_WIDTH'(1);
            if (r_err_count == '0) begin
               r_first_got <= u_data;
               r_first_exp <= r_expected;
            end
         end
      end
   end

   // Hold-rule monitor: remember last cycle's beat, flag sticky violations.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_prev_vld  <= 1'b0;
         r_prev_hs   <= 1'b0;
         r_prev_data <= '0;
         r_arm       <= 1'b0;
         r_proto_err <= 1'b0;
      end else begin
         r_prev_vld  <= u_valid;
         r_prev_hs   <= w_hs;
         r_prev_data <= u_data;
         if (w_start_ok) begin
            // Upstream may not have seen ready yet; skip the first ACCEPT cycle.
            r_arm       <= 1'b0;
            r_proto_err <= 1'b0;
         end else begin
            if (r_state != S_IDLE) r_arm <= 1'b1;
            if (w_hold_viol)       r_proto_err <= 1'b1;
         end
      end
   end

   assign u_ready       = r_ready;
   assign busy          = (r_state == S_ACCEPT) || (r_state == S_STALL);
   assign done          = (r_state == S_DONE);
   assign pass          = done && (r_err_count == '0) && !r_proto_err;
   assign rx_count      = r_rx_count;
   assign err_count     = r_err_count;
   assign proto_err     = r_proto_err;
   assign first_err_got = r_first_got;
   assign first_err_exp = r_first_exp;

endmodule

// File: tb/tb_stream_sink_checker.sv
// Directed bench for stream_sink_checker: a main 32-bit instance and a
// 4-bit instance for the wrap case. Source drives just after each rising
// edge; outputs are read there too, handshakes are sampled on the falling edge.
module tb_stream_sink_checker;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] u_data;
   logic        u_valid, u_ready, start, busy, done, pass, proto_err;
   logic [15:0] rx_count, err_count;
   logic [31:0] first_err_got, first_err_exp;

   logic [3:0]  d4, fg4, fe4;
   logic        v4, r4, start4, busy4, done4, pass4, proto4;
   logic [15:0] rx4, err4;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   stream_sink_checker #(.DATA_WIDTH(32), .COUNT_WIDTH(16), .EXPECT_COUNT(100),
                         .DATA_START(0), .STALL_N(2), .LFSR_SEED(16'hACE1)) dut (
      .clk(clk), .rst_n(rst_n), .u_data(u_data), .u_valid(u_valid), .u_ready(u_ready),
      .start(start), .busy(busy), .done(done), .pass(pass), .rx_count(rx_count),
      .err_count(err_count), .proto_err(proto_err), .first_err_got(first_err_got),
      .first_err_exp(first_err_exp));

   stream_sink_checker #(.DATA_WIDTH(4), .COUNT_WIDTH(16), .EXPECT_COUNT(4),
                         .DATA_START(14), .STALL_N(2), .LFSR_SEED(16'h1234)) dut4 (
      .clk(clk), .rst_n(rst_n), .u_data(d4), .u_valid(v4), .u_ready(r4),
      .start(start4), .busy(busy4), .done(done4), .pass(pass4), .rx_count(rx4),
      .err_count(err4), .proto_err(proto4), .first_err_got(fg4), .first_err_exp(fe4));

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Sends beats [from,to) with random bubbles, holding data while stalled.
   task automatic send_beats(input int from, input int to, input int bub, input int bad_idx,
                             input logic [31:0] bad_val, input bit stall_start, output bit saw_stall);
      int idx, cyc;
      bit hs;
      idx = from; cyc = 0; saw_stall = 1'b0;
      while (idx < to) begin
         start = 1'b0;
         if (stall_start && !saw_stall && busy && !u_ready) begin
            start = 1'b1;
            saw_stall = 1'b1;
         end
         if (!u_valid && ($urandom_range(99) >= bub)) begin
            u_valid = 1'b1;
            u_data  = (idx == bad_idx) ? bad_val : 32'(idx);
         end
         @(negedge clk); hs = u_valid && u_ready;
         @(posedge clk); #1;
         if (hs) begin idx++; u_valid = 1'b0; end
         cyc++;
         if (cyc > 3000) begin
            n_cmp++; n_bad++;
            $display("FAIL src_timeout: beat %0d of %0d never accepted", idx, to);
            u_valid = 1'b0;
            break;
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; u_valid = 1'b0; u_data = '0;
      start4 = 1'b0; v4 = 1'b0; d4 = '0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (u_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", u_ready); end
      n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin n_bad++; $display("FAIL rst_flags: got busy=%b done=%b pass=%b want 000", busy, done, pass); end
      n_cmp++; if (rx_count !== 16'd0 || err_count !== 16'd0) begin n_bad++; $display("FAIL rst_counts: got rx=%0d err=%0d want 0/0", rx_count, err_count); end
      n_cmp++; if (proto_err !== 1'b0) begin n_bad++; $display("FAIL rst_proto: got %b want 0", proto_err); end
      n_cmp++; if (first_err_got !== 32'd0 || first_err_exp !== 32'd0) begin n_bad++; $display("FAIL rst_first: got %h/%h want 0/0", first_err_got, first_err_exp); end
      n_cmp++; if (r4 !== 1'b0 || done4 !== 1'b0) begin n_bad++; $display("FAIL rst_dut4: got ready=%b done=%b want 0/0", r4, done4); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_clean_run();
      bit dummy;
      pulse_start();
      n_cmp++; if (u_ready !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL first_ready: got ready=%b busy=%b want 1/1", u_ready, busy); end
      send_beats(0, 100, 30, -1, 32'd0, 1'b0, dummy);
      n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL clean_done: got done=%b busy=%b want 1/0", done, busy); end
      n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL clean_pass: got %b want 1", pass); end
      n_cmp++; if (rx_count !== 16'd100) begin n_bad++; $display("FAIL clean_rx: got %0d want 100", rx_count); end
      n_cmp++; if (err_count !== 16'd0 || proto_err !== 1'b0) begin n_bad++; $display("FAIL clean_errs: got err=%0d proto=%b want 0/0", err_count, proto_err); end
      n_cmp++; if (u_ready !== 1'b0) begin n_bad++; $display("FAIL done_ready: got %b want 0", u_ready); end
   endtask

   task automatic test_data_error();
      bit dummy;
      pulse_start();
      send_beats(0, 100, 25, 5, 32'h55, 1'b0, dummy);
      n_cmp++; if (done !== 1'b1 || rx_count !== 16'd100) begin n_bad++; $display("FAIL derr_done: got done=%b rx=%0d want 1/100", done, rx_count); end
      n_cmp++; if (err_count !== 16'd1) begin n_bad++; $display("FAIL derr_count: got %0d want 1", err_count); end
      n_cmp++; if (first_err_got !== 32'h55) begin n_bad++; $display("FAIL derr_got: got %h want 00000055", first_err_got); end
      n_cmp++; if (first_err_exp !== 32'd5) begin n_bad++; $display("FAIL derr_exp: got %h want 00000005", first_err_exp); end
      n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL derr_pass: got %b want 0", pass); end
   endtask

   // Needs beat 7 pending during a stall; retries whole runs until the
   // stall pattern puts one right after beat 6.
   task automatic test_proto_err();
      bit hit, hs, dummy;
      int k;
      hit = 1'b0;
      for (int a = 0; a < 30 && !hit; a++) begin
         pulse_start();
         send_beats(0, 7, 0, -1, 32'd0, 1'b0, dummy);
         if (!u_ready) begin
            hit = 1'b1;
            u_valid = 1'b1; u_data = 32'd7;
            @(posedge clk); #1;
            u_data = 32'd8;
            @(negedge clk); hs = u_valid && u_ready;
            @(posedge clk); #1;
            n_cmp++; if (proto_err !== 1'b1) begin n_bad++; $display("FAIL proto_set: got %b want 1", proto_err); end
            k = 0;
            while (!hs && k < 20) begin
               @(negedge clk); hs = u_valid && u_ready;
               @(posedge clk); #1;
               k++;
            end
            u_valid = 1'b0;
            send_beats(8, 100, 20, -1, 32'd0, 1'b0, dummy);
         end else begin
            send_beats(7, 100, 0, -1, 32'd0, 1'b0, dummy);
         end
      end
      n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL proto_stall_found: got %b want 1", hit); end
      n_cmp++; if (done !== 1'b1 || proto_err !== 1'b1) begin n_bad++; $display("FAIL proto_sticky: got done=%b proto=%b want 1/1", done, proto_err); end
      n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL proto_pass: got %b want 0", pass); end
   endtask

   task automatic test_wrap();
      int idx, cyc;
      bit hs;
      start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      idx = 0; cyc = 0;
      while (idx < 4 && cyc < 200) begin
         if (!v4) begin v4 = 1'b1; d4 = 4'(14 + idx); end
         @(negedge clk); hs = v4 && r4;
         @(posedge clk); #1;
         cyc++;
         if (hs) begin idx++; v4 = 1'b0; end
      end
      v4 = 1'b0;
      n_cmp++; if (done4 !== 1'b1 || rx4 !== 16'd4) begin n_bad++; $display("FAIL wrap_done: got done=%b rx=%0d want 1/4", done4, rx4); end
      n_cmp++; if (pass4 !== 1'b1 || err4 !== 16'd0) begin n_bad++; $display("FAIL wrap_pass: got pass=%b err=%0d want 1/0", pass4, err4); end
   endtask

   task automatic test_reset_midrun();
      bit dummy;
      pulse_start();
      send_beats(0, 10, 0, -1, 32'd0, 1'b0, dummy);
      // start coincides with reset: reset wins.
      rst_n = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (u_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin n_bad++; $display("FAIL mrst_flags: got ready=%b busy=%b done=%b pass=%b want 0000", u_ready, busy, done, pass); end
      n_cmp++; if (rx_count !== 16'd0 || err_count !== 16'd0 || proto_err !== 1'b0) begin n_bad++; $display("FAIL mrst_counts: got rx=%0d err=%0d proto=%b want 0/0/0", rx_count, err_count, proto_err); end
      rst_n = 1'b1; start = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mrst_idle: got busy=%b want 0", busy); end
      pulse_start();
      send_beats(0, 100, 15, -1, 32'd0, 1'b0, dummy);
      n_cmp++; if (pass !== 1'b1 || rx_count !== 16'd100) begin n_bad++; $display("FAIL mrst_rerun: got pass=%b rx=%0d want 1/100", pass, rx_count); end
   endtask

   task automatic test_restart();
      bit saw, dummy;
      pulse_start();
      send_beats(0, 100, 10, -1, 32'd0, 1'b1, saw);
      n_cmp++; if (saw !== 1'b1) begin n_bad++; $display("FAIL stall_start_seen: got %b want 1", saw); end
      n_cmp++; if (done !== 1'b1 || pass !== 1'b1 || rx_count !== 16'd100) begin n_bad++; $display("FAIL stall_start_ignored: got done=%b pass=%b rx=%0d want 1/1/100", done, pass, rx_count); end
      pulse_start();
      n_cmp++; if (rx_count !== 16'd0 || err_count !== 16'd0) begin n_bad++; $display("FAIL restart_clear: got rx=%0d err=%0d want 0/0", rx_count, err_count); end
      n_cmp++; if (u_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL restart_ready: got ready=%b busy=%b done=%b want 1/1/0", u_ready, busy, done); end
      send_beats(0, 100, 0, -1, 32'd0, 1'b0, dummy);
      n_cmp++; if (pass !== 1'b1 || rx_count !== 16'd100) begin n_bad++; $display("FAIL restart_run: got pass=%b rx=%0d want 1/100", pass, rx_count); end
   endtask

   initial begin
      test_reset();
      test_clean_run();
      test_data_error();
      test_proto_err();
      test_wrap();
      test_reset_midrun();
      test_restart();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
